// File: rtl/tx_on_detection_mc_pkg.sv
// tx_on_detection_mc shared types: channel states,
// detection modes and RF transition directions.
package tx_on_det_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ARMED = 2'd1,
      RUN   = 2'd2,
      DRAIN = 2'd3
   } ch_state_e;

   localparam logic MODE_FIFO = 1'b0;
   localparam logic MODE_PHY  = 1'b1;

   localparam logic DIR_FALL = 1'b0;
   localparam logic DIR_RISE = 1'b1;

endpackage

// File: rtl/tx_on_detection_mc_if.sv
// PHY-side inputs and BB/RF status outputs of the
// multi-channel TX activity detector.
interface tx_on_detection_mc_if #(
   parameter int N_CH = 2
);
   logic            phy_tx_started;
   logic            phy_tx_done;
   logic [N_CH-1:0] tx_iq_fifo_empty;
   logic [N_CH-1:0] tx_bb_ch_active;
   logic            tx_bb_is_ongoing;
   logic            pulse_tx_bb_start;
   logic            pulse_tx_bb_end;
   logic            tx_rf_is_ongoing;
   logic            tx_bb_timeout;

   modport master (
      output phy_tx_started, phy_tx_done, tx_iq_fifo_empty,
      input  tx_bb_ch_active, tx_bb_is_ongoing,
      input  pulse_tx_bb_start, pulse_tx_bb_end,
      input  tx_rf_is_ongoing, tx_bb_timeout
   );

   modport slave (
      input  phy_tx_started, phy_tx_done, tx_iq_fifo_empty,
      output tx_bb_ch_active, tx_bb_is_ongoing,
      output pulse_tx_bb_start, pulse_tx_bb_end,
      output tx_rf_is_ongoing, tx_bb_timeout
   );
endinterface

// File: rtl/tx_on_detection_mc_ch.sv
// One TX IQ channel: activity FSM, FIFO-empty edge
// register and stuck-TX watchdog.
module tx_on_det_ch
   import tx_on_det_pkg::*;
#(
   parameter int TO_W = 20
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            en_i,
   input  logic            mode_i,
   input  logic            started_i,
   input  logic            done_i,
   input  logic            empty_i,
   input  logic [TO_W-1:0] timeout_i,
   output logic            active_o,
   output logic            timeout_o
);
   localparam logic [1:0] S_IDLE  = IDLE;
   localparam logic [1:0] S_ARMED = ARMED;
   localparam logic [1:0] S_RUN   = RUN;
   localparam logic [1:0] S_DRAIN = DRAIN;

   logic [1:0]      state_q, state_d;
   logic            empty_q;
   logic [TO_W-1:0] cnt_q, cnt_d;
   logic            fall_e, rise_e, busy, only_done;

   assign fall_e    = empty_q & ~empty_i;
   assign rise_e    = ~empty_q & empty_i;
   assign busy      = state_q != S_IDLE;
   assign only_done = done_i & ~started_i;
   assign active_o  = (state_q == S_RUN) || (state_q == S_DRAIN);
   assign timeout_o = busy && (timeout_i != '0)
                      && (cnt_q == timeout_i - TO_W'(1));

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         S_IDLE: begin
            if (started_i)
               state_d = (mode_i == MODE_PHY) ? S_RUN : S_ARMED;
         end
         S_ARMED: begin
            if (only_done)   state_d = S_IDLE;
            else if (fall_e) state_d = S_RUN;
         end
         S_RUN: begin
            if (only_done)
               state_d = (mode_i == MODE_PHY) ? S_IDLE : S_DRAIN;
         end
         S_DRAIN: begin
            if (started_i)   state_d = S_RUN;
            else if (rise_e) state_d = S_IDLE;
         end
      endcase
      if (timeout_o || !en_i) state_d = S_IDLE;
   end

   // count starts at 0 on the first non-IDLE cycle
   always_comb begin
      cnt_d = cnt_q;
      if (state_d == S_IDLE)
         cnt_d = '0;
      else if (busy && (cnt_q != '1))
         cnt_d = cnt_q + TO_W'(1);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         empty_q <= 1'b1;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         empty_q <= empty_i;
         cnt_q   <= cnt_d;
      end
   end
endmodule

// File: rtl/tx_on_detection_mc.sv
// Multi-channel TX activity detector: aggregate BB
// flag with stretch and pulses, plus delayed RF flag.
module tx_on_detection_mc
   import tx_on_det_pkg::*;
#(
   parameter int N_CH        = 2,
   parameter int DLY_W       = 14,
   parameter int COUNT_SCALE = 100,
   parameter int EXT_CYC     = 4,
   parameter int TO_W        = 20
) (
   input logic             clk,
   input logic             rst,
   input logic [N_CH-1:0]  cfg_ch_en,
   input logic             cfg_mode,
   input logic [DLY_W-1:0] cfg_rise_delay,
   input logic [DLY_W-1:0] cfg_fall_delay,
   input logic [TO_W-1:0]  cfg_timeout,
   tx_on_detection_mc_if.slave bus
);
   localparam int TW = DLY_W + $clog2(COUNT_SCALE) + 1;

   logic [N_CH-1:0]    ch_act, ch_to;
   logic               bb_int, pls_start, pls_end;
   logic [EXT_CYC-1:0] bb_dly_q, bb_dly_d;
   logic [EXT_CYC:0]   bb_sh;
   logic [TW-1:0]      rise_sc_q, rise_sc_d, fall_sc_q, fall_sc_d;
   logic [TW-1:0]      tgt_q, tgt_d, cnt_q, cnt_d;
   logic               dir_q, dir_d, rf_q, rf_d;

   for (genvar g = 0; g < N_CH; g++) begin : g_ch
      tx_on_det_ch #(.TO_W(TO_W)) u_ch (
         .clk       (clk),
         .rst       (rst),
         .en_i      (cfg_ch_en[g]),
         .mode_i    (cfg_mode),
         .started_i (bus.phy_tx_started),
         .done_i    (bus.phy_tx_done),
         .empty_i   (bus.tx_iq_fifo_empty[g]),
         .timeout_i (cfg_timeout),
         .active_o  (ch_act[g]),
         .timeout_o (ch_to[g])
      );
   end

   assign bb_int    = |ch_act;
   assign bb_sh     = {bb_dly_q, bb_int};
   assign bb_dly_d  = bb_sh[EXT_CYC-1:0];
   assign pls_start = bb_int & ~bb_dly_q[0];
   assign pls_end   = ~bb_int & bb_dly_q[0];

   assign bus.tx_bb_ch_active   = ch_act;
   assign bus.tx_bb_is_ongoing  = bb_int | (|bb_dly_q);
   assign bus.pulse_tx_bb_start = pls_start;
   assign bus.pulse_tx_bb_end   = pls_end;
   assign bus.tx_rf_is_ongoing  = rf_q;
   assign bus.tx_bb_timeout     = |ch_to;

   // a new pulse retargets the counter, cancelling any pending edge
   always_comb begin
      rise_sc_d = TW'(cfg_rise_delay) * TW'(COUNT_SCALE);
      fall_sc_d = TW'(cfg_fall_delay) * TW'(COUNT_SCALE);
      tgt_d = tgt_q;
      cnt_d = cnt_q;
      dir_d = dir_q;
      rf_d  = rf_q;
      if (pls_start || pls_end) begin
         tgt_d = pls_start ? rise_sc_q : fall_sc_q;
         cnt_d = '0;
         dir_d = pls_start ? DIR_RISE : DIR_FALL;
      end else if (cnt_q != tgt_q + TW'(1)) begin
         cnt_d = cnt_q + TW'(1);
      end
      if (cnt_q == tgt_q) rf_d = dir_q;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         bb_dly_q  <= '0;
         rise_sc_q <= '0;
         fall_sc_q <= '0;
         tgt_q     <= '0;
         cnt_q     <= '0;
         dir_q     <= DIR_FALL;
         rf_q      <= 1'b0;
      end else begin
         bb_dly_q  <= bb_dly_d;
         rise_sc_q <= rise_sc_d;
         fall_sc_q <= fall_sc_d;
         tgt_q     <= tgt_d;
         cnt_q     <= cnt_d;
         dir_q     <= dir_d;
         rf_q      <= rf_d;
      end
   end
endmodule

// File: tb/tb_tx_on_detection_mc.sv
// Scoreboard bench for tx_on_detection_mc: expected
// events are queued at stimulus time, compared to observed.
module tb_tx_on_detection_mc;
   import tx_on_det_pkg::*;

   localparam int N_CH = 2;
   localparam int DLY_W = 14;
   localparam int SC = 100;
   localparam int EXT = 4;
   localparam int TO_W = 20;

   localparam int EV_START = 0;
   localparam int EV_END = 1;
   localparam int EV_RFR = 2;
   localparam int EV_RFF = 3;
   localparam int EV_TO = 4;
   localparam int EV_BBF = 5;

   typedef struct packed {
      int kind;
      int cyc;
   } ev_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic [N_CH-1:0] cfg_ch_en = '0;
   logic cfg_mode = MODE_FIFO;
   logic [DLY_W-1:0] cfg_rise_delay = '0;
   logic [DLY_W-1:0] cfg_fall_delay = '0;
   logic [TO_W-1:0] cfg_timeout = '0;

   int cyc = 0;
   int tests = 0;
   int failed = 0;
   ev_t exp_q[$];
   ev_t obs_q[$];
   logic p_rf = 1'b0;
   logic p_on = 1'b0;

   tx_on_detection_mc_if #(.N_CH(N_CH)) bus();

   tx_on_detection_mc #(
      .N_CH(N_CH), .DLY_W(DLY_W), .COUNT_SCALE(SC),
      .EXT_CYC(EXT), .TO_W(TO_W)
   ) dut (
      .clk(clk),
      .rst(rst),
      .cfg_ch_en(cfg_ch_en),
      .cfg_mode(cfg_mode),
      .cfg_rise_delay(cfg_rise_delay),
      .cfg_fall_delay(cfg_fall_delay),
      .cfg_timeout(cfg_timeout),
      .bus(bus)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (bus.pulse_tx_bb_start === 1'b1)
         obs_q.push_back(ev_t'{EV_START, cyc});
      if (bus.pulse_tx_bb_end === 1'b1)
         obs_q.push_back(ev_t'{EV_END, cyc});
      if (bus.tx_rf_is_ongoing === 1'b1 && p_rf === 1'b0)
         obs_q.push_back(ev_t'{EV_RFR, cyc});
      if (bus.tx_rf_is_ongoing === 1'b0 && p_rf === 1'b1)
         obs_q.push_back(ev_t'{EV_RFF, cyc});
      if (bus.tx_bb_timeout === 1'b1)
         obs_q.push_back(ev_t'{EV_TO, cyc});
      if (bus.tx_bb_is_ongoing === 1'b0 && p_on === 1'b1)
         obs_q.push_back(ev_t'{EV_BBF, cyc});
      p_rf <= bus.tx_rf_is_ongoing;
      p_on <= bus.tx_bb_is_ongoing;
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic setup(input logic [N_CH-1:0] en, input logic mode,
                        input int rise, input int fall, input int to);
      cfg_ch_en = en;
      cfg_mode = mode;
      cfg_rise_delay = DLY_W'(rise);
      cfg_fall_delay = DLY_W'(fall);
      cfg_timeout = TO_W'(to);
      bus.phy_tx_started = 1'b0;
      bus.phy_tx_done = 1'b0;
      bus.tx_iq_fifo_empty = '1;
      repeat (3) step();
      exp_q.delete();
      obs_q.delete();
   endtask

   task automatic test_reset();
      rst = 1'b1;
      cfg_ch_en = '1;
      bus.phy_tx_started = 1'b0;
      bus.phy_tx_done = 1'b0;
      bus.tx_iq_fifo_empty = '1;
      repeat (3) step();
      tests++;
      if (bus.tx_bb_ch_active !== 2'b00) begin
         failed++;
         $display("FAIL reset active: got %b want 00", bus.tx_bb_ch_active);
      end
      tests++;
      if (bus.tx_bb_is_ongoing !== 1'b0) begin
         failed++;
         $display("FAIL reset ongoing: got %b want 0", bus.tx_bb_is_ongoing);
      end
      tests++;
      if (bus.pulse_tx_bb_start !== 1'b0 || bus.pulse_tx_bb_end !== 1'b0) begin
         failed++;
         $display("FAIL reset pulses: got %b%b want 00",
                  bus.pulse_tx_bb_start, bus.pulse_tx_bb_end);
      end
      tests++;
      if (bus.tx_rf_is_ongoing !== 1'b0) begin
         failed++;
         $display("FAIL reset rf: got %b want 0", bus.tx_rf_is_ongoing);
      end
      tests++;
      if (bus.tx_bb_timeout !== 1'b0) begin
         failed++;
         $display("FAIL reset timeout: got %b want 0", bus.tx_bb_timeout);
      end
      rst = 1'b0;
      step();
   endtask

   task automatic test_single();
      int b;
      ev_t e, o;
      setup(2'b01, MODE_FIFO, 2, 3, 0);
      b = cyc;
      for (int k = 0; k <= 820; k++) begin
         bus.phy_tx_started = (k == 2);
         bus.phy_tx_done = (k == 400);
         if (k == 10) begin
            bus.tx_iq_fifo_empty[0] = 1'b0;
            exp_q.push_back(ev_t'{EV_START, b + 11});
            exp_q.push_back(ev_t'{EV_RFR, b + 11 + 2 * SC + 2});
         end
         if (k == 500) begin
            bus.tx_iq_fifo_empty[0] = 1'b1;
            exp_q.push_back(ev_t'{EV_END, b + 501});
            exp_q.push_back(ev_t'{EV_BBF, b + 505});
            exp_q.push_back(ev_t'{EV_RFF, b + 501 + 3 * SC + 2});
         end
         if (k == 300) begin
            tests++;
            if (bus.tx_bb_ch_active !== 2'b01) begin
               failed++;
               $display("FAIL single active: got %b want 01", bus.tx_bb_ch_active);
            end
         end
         step();
      end
      while (exp_q.size() != 0) begin
         e = exp_q.pop_front();
         if (obs_q.size() != 0) o = obs_q.pop_front();
         else o = ev_t'{-1, -1};
         tests++;
         if (o !== e) begin
            failed++;
            $display("FAIL single ev: got kind %0d @%0d want kind %0d @%0d",
                     o.kind, o.cyc - b, e.kind, e.cyc - b);
         end
      end
      tests++;
      if (obs_q.size() != 0) begin
         failed++;
         $display("FAIL single extra: got %0d events want 0", obs_q.size());
      end
   endtask

   task automatic test_two_ch();
      int b;
      ev_t e, o;
      logic [N_CH-1:0] want;
      setup(2'b11, MODE_FIFO, 2, 3, 0);
      b = cyc;
      for (int k = 0; k <= 560; k++) begin
         bus.phy_tx_started = (k == 2);
         bus.phy_tx_done = (k == 100);
         if (k == 10) begin
            bus.tx_iq_fifo_empty[0] = 1'b0;
            exp_q.push_back(ev_t'{EV_START, b + 11});
            exp_q.push_back(ev_t'{EV_RFR, b + 213});
         end
         if (k == 12) bus.tx_iq_fifo_empty[1] = 1'b0;
         if (k == 200) bus.tx_iq_fifo_empty[0] = 1'b1;
         if (k == 240) begin
            bus.tx_iq_fifo_empty[1] = 1'b1;
            exp_q.push_back(ev_t'{EV_END, b + 241});
            exp_q.push_back(ev_t'{EV_BBF, b + 245});
            exp_q.push_back(ev_t'{EV_RFF, b + 543});
         end
         if (k == 12 || k == 13 || k == 220 || k == 241) begin
            if (k == 12) want = 2'b01;
            else if (k == 13) want = 2'b11;
            else if (k == 220) want = 2'b10;
            else want = 2'b00;
            tests++;
            if (bus.tx_bb_ch_active !== want) begin
               failed++;
               $display("FAIL two_ch active @%0d: got %b want %b",
                        k, bus.tx_bb_ch_active, want);
            end
         end
         step();
      end
      while (exp_q.size() != 0) begin
         e = exp_q.pop_front();
         if (obs_q.size() != 0) o = obs_q.pop_front();
         else o = ev_t'{-1, -1};
         tests++;
         if (o !== e) begin
            failed++;
            $display("FAIL two_ch ev: got kind %0d @%0d want kind %0d @%0d",
                     o.kind, o.cyc - b, e.kind, e.cyc - b);
         end
      end
      tests++;
      if (obs_q.size() != 0) begin
         failed++;
         $display("FAIL two_ch extra: got %0d events want 0", obs_q.size());
      end
   endtask

   task automatic test_short_burst();
      int b;
      ev_t e, o;
      setup(2'b01, MODE_FIFO, 10, 3, 0);
      b = cyc;
      for (int k = 0; k <= 1100; k++) begin
         bus.phy_tx_started = (k == 2);
         bus.phy_tx_done = (k == 200);
         if (k == 10) begin
            bus.tx_iq_fifo_empty[0] = 1'b0;
            exp_q.push_back(ev_t'{EV_START, b + 11});
         end
         if (k == 310) begin
            bus.tx_iq_fifo_empty[0] = 1'b1;
            exp_q.push_back(ev_t'{EV_END, b + 311});
            exp_q.push_back(ev_t'{EV_BBF, b + 315});
         end
         step();
      end
      while (exp_q.size() != 0) begin
         e = exp_q.pop_front();
         if (obs_q.size() != 0) o = obs_q.pop_front();
         else o = ev_t'{-1, -1};
         tests++;
         if (o !== e) begin
            failed++;
            $display("FAIL short ev: got kind %0d @%0d want kind %0d @%0d",
                     o.kind, o.cyc - b, e.kind, e.cyc - b);
         end
      end
      tests++;
      if (obs_q.size() != 0) begin
         failed++;
         $display("FAIL short extra: got %0d events want 0", obs_q.size());
      end
   endtask

   task automatic test_back_to_back();
      int b;
      ev_t e, o;
      setup(2'b01, MODE_FIFO, 2, 5, 0);
      b = cyc;
      for (int k = 0; k <= 1270; k++) begin
         bus.phy_tx_started = (k == 2) || (k == 440);
         bus.phy_tx_done = (k == 300) || (k == 700);
         if (k == 10) begin
            bus.tx_iq_fifo_empty[0] = 1'b0;
            exp_q.push_back(ev_t'{EV_START, b + 11});
            exp_q.push_back(ev_t'{EV_RFR, b + 213});
         end
         if (k == 400) begin
            bus.tx_iq_fifo_empty[0] = 1'b1;
            exp_q.push_back(ev_t'{EV_END, b + 401});
            exp_q.push_back(ev_t'{EV_BBF, b + 405});
         end
         if (k == 450) begin
            bus.tx_iq_fifo_empty[0] = 1'b0;
            exp_q.push_back(ev_t'{EV_START, b + 451});
         end
         if (k == 750) begin
            bus.tx_iq_fifo_empty[0] = 1'b1;
            exp_q.push_back(ev_t'{EV_END, b + 751});
            exp_q.push_back(ev_t'{EV_BBF, b + 755});
            exp_q.push_back(ev_t'{EV_RFF, b + 751 + 5 * SC + 2});
         end
         step();
      end
      while (exp_q.size() != 0) begin
         e = exp_q.pop_front();
         if (obs_q.size() != 0) o = obs_q.pop_front();
         else o = ev_t'{-1, -1};
         tests++;
         if (o !== e) begin
            failed++;
            $display("FAIL b2b ev: got kind %0d @%0d want kind %0d @%0d",
                     o.kind, o.cyc - b, e.kind, e.cyc - b);
         end
      end
      tests++;
      if (obs_q.size() != 0) begin
         failed++;
         $display("FAIL b2b extra: got %0d events want 0", obs_q.size());
      end
   endtask

   task automatic test_phy_mode();
      int b;
      ev_t e, o;
      setup(2'b01, MODE_PHY, 0, 0, 0);
      b = cyc;
      for (int k = 0; k <= 270; k++) begin
         bus.phy_tx_started = (k == 5) || (k == 150);
         bus.phy_tx_done = (k == 105) || (k == 150) || (k == 250);
         bus.tx_iq_fifo_empty[0] = !(k >= 50 && k < 60);
         if (k == 5) begin
            exp_q.push_back(ev_t'{EV_START, b + 6});
            exp_q.push_back(ev_t'{EV_RFR, b + 8});
         end
         if (k == 105) begin
            exp_q.push_back(ev_t'{EV_END, b + 106});
            exp_q.push_back(ev_t'{EV_RFF, b + 108});
            exp_q.push_back(ev_t'{EV_BBF, b + 110});
         end
         if (k == 150) begin
            exp_q.push_back(ev_t'{EV_START, b + 151});
            exp_q.push_back(ev_t'{EV_RFR, b + 153});
         end
         if (k == 250) begin
            exp_q.push_back(ev_t'{EV_END, b + 251});
            exp_q.push_back(ev_t'{EV_RFF, b + 253});
            exp_q.push_back(ev_t'{EV_BBF, b + 255});
         end
         if (k == 105 || k == 106) begin
            tests++;
            if (bus.tx_bb_ch_active[0] !== (k == 105)) begin
               failed++;
               $display("FAIL phy active @%0d: got %b want %b",
                        k, bus.tx_bb_ch_active[0], (k == 105));
            end
         end
         step();
      end
      while (exp_q.size() != 0) begin
         e = exp_q.pop_front();
         if (obs_q.size() != 0) o = obs_q.pop_front();
         else o = ev_t'{-1, -1};
         tests++;
         if (o !== e) begin
            failed++;
            $display("FAIL phy ev: got kind %0d @%0d want kind %0d @%0d",
                     o.kind, o.cyc - b, e.kind, e.cyc - b);
         end
      end
      tests++;
      if (obs_q.size() != 0) begin
         failed++;
         $display("FAIL phy extra: got %0d events want 0", obs_q.size());
      end
   endtask

   task automatic test_watchdog(input int to);
      int b;
      int last;
      ev_t e, o;
      setup(2'b01, MODE_FIFO, 2, 3, to);
      b = cyc;
      last = (to != 0) ? 1320 : 2720;
      for (int k = 0; k <= last; k++) begin
         bus.phy_tx_started = (k == 2);
         bus.phy_tx_done = (k == 100);
         if (k == 10) begin
            bus.tx_iq_fifo_empty[0] = 1'b0;
            exp_q.push_back(ev_t'{EV_START, b + 11});
            exp_q.push_back(ev_t'{EV_RFR, b + 213});
            if (to != 0) begin
               exp_q.push_back(ev_t'{EV_TO, b + 3 + to - 1});
               exp_q.push_back(ev_t'{EV_END, b + 3 + to});
               exp_q.push_back(ev_t'{EV_BBF, b + 3 + to + 4});
               exp_q.push_back(ev_t'{EV_RFF, b + 3 + to + 302});
            end
         end
         if (to == 0 && k == 2400) begin
            cfg_ch_en = 2'b00;
            exp_q.push_back(ev_t'{EV_END, b + 2401});
            exp_q.push_back(ev_t'{EV_BBF, b + 2405});
            exp_q.push_back(ev_t'{EV_RFF, b + 2703});
         end
         step();
      end
      while (exp_q.size() != 0) begin
         e = exp_q.pop_front();
         if (obs_q.size() != 0) o = obs_q.pop_front();
         else o = ev_t'{-1, -1};
         tests++;
         if (o !== e) begin
            failed++;
            $display("FAIL wdog%0d ev: got kind %0d @%0d want kind %0d @%0d",
                     to, o.kind, o.cyc - b, e.kind, e.cyc - b);
         end
      end
      tests++;
      if (obs_q.size() != 0) begin
         failed++;
         $display("FAIL wdog%0d extra: got %0d events want 0", to, obs_q.size());
      end
   endtask

   task automatic test_reset_mid();
      int b;
      ev_t e, o;
      setup(2'b01, MODE_FIFO, 2, 3, 0);
      b = cyc;
      for (int k = 0; k <= 920; k++) begin
         rst = (k == 300);
         bus.phy_tx_started = (k == 2) || (k == 320);
         bus.phy_tx_done = 1'b0;
         if (k == 10) begin
            bus.tx_iq_fifo_empty[0] = 1'b0;
            exp_q.push_back(ev_t'{EV_START, b + 11});
            exp_q.push_back(ev_t'{EV_RFR, b + 213});
         end
         if (k == 300) begin
            tests++;
            if (bus.tx_rf_is_ongoing !== 1'b1) begin
               failed++;
               $display("FAIL rstmid rf before: got %b want 1", bus.tx_rf_is_ongoing);
            end
            exp_q.push_back(ev_t'{EV_RFF, b + 301});
            exp_q.push_back(ev_t'{EV_BBF, b + 301});
         end
         if (k == 301) begin
            bus.tx_iq_fifo_empty[0] = 1'b1;
            tests++;
            if ({bus.tx_bb_ch_active, bus.tx_bb_is_ongoing, bus.pulse_tx_bb_end,
                 bus.tx_rf_is_ongoing} !== 5'b0) begin
               failed++;
               $display("FAIL rstmid after: got act=%b on=%b end=%b rf=%b want all 0",
                        bus.tx_bb_ch_active, bus.tx_bb_is_ongoing,
                        bus.pulse_tx_bb_end, bus.tx_rf_is_ongoing);
            end
         end
         if (k == 330) begin
            bus.tx_iq_fifo_empty[0] = 1'b0;
            exp_q.push_back(ev_t'{EV_START, b + 331});
            exp_q.push_back(ev_t'{EV_RFR, b + 533});
         end
         if (k == 600) begin
            cfg_ch_en = 2'b00;
            exp_q.push_back(ev_t'{EV_END, b + 601});
            exp_q.push_back(ev_t'{EV_BBF, b + 605});
            exp_q.push_back(ev_t'{EV_RFF, b + 903});
         end
         if (k == 601) begin
            tests++;
            if (bus.tx_bb_ch_active !== 2'b00) begin
               failed++;
               $display("FAIL chen active: got %b want 00", bus.tx_bb_ch_active);
            end
         end
         step();
      end
      while (exp_q.size() != 0) begin
         e = exp_q.pop_front();
         if (obs_q.size() != 0) o = obs_q.pop_front();
         else o = ev_t'{-1, -1};
         tests++;
         if (o !== e) begin
            failed++;
            $display("FAIL rstmid ev: got kind %0d @%0d want kind %0d @%0d",
                     o.kind, o.cyc - b, e.kind, e.cyc - b);
         end
      end
      tests++;
      if (obs_q.size() != 0) begin
         failed++;
         $display("FAIL rstmid extra: got %0d events want 0", obs_q.size());
      end
   endtask

   initial begin
      test_reset();
      test_single();
      test_two_ch();
      test_short_burst();
      test_back_to_back();
      test_phy_mode();
      test_watchdog(1000);
      test_watchdog(0);
      test_reset_mid();
      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end
endmodule
